// File: rtl/decode138_pkg.sv
// decode138_pkg: shared widths, inactive output pattern and the one-cold
// decode helper used by the 74LS138-style 3-to-8 decoder.
package decode138_pkg;

  localparam int ADDR_W = 3;
  localparam int NUM_OUT = 8;
  localparam logic [NUM_OUT-1:0] Y_INACTIVE = 8'hFF;

  // Maps an address and the combined enable to an active-low one-cold vector.
  // With the enable low every output stays high, so the address is ignored.
  function automatic logic [NUM_OUT-1:0] decode_one_cold(
    input logic [ADDR_W-1:0] addr,
    input logic              en
  );
    logic [NUM_OUT-1:0] vec;
    vec = Y_INACTIVE;
    if (en) begin
      vec[addr] = 1'b0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/decode138_if.sv
// decode138_if: groups the address, enable and decoded output pins of the
// 74LS138-style decoder. The master drives address/enables and observes the
// outputs; the slave (the decoder) does the opposite.
interface decode138_if;

  logic A0;
  logic A1;
  logic A2;
  logic E1;
  logic E2_n;
  logic E3_n;
  logic Y0_n;
  logic Y1_n;
  logic Y2_n;
  logic Y3_n;
  logic Y4_n;
  logic Y5_n;
  logic Y6_n;
  logic Y7_n;

  modport master (
    output A0, A1, A2, E1, E2_n, E3_n,
    input  Y0_n, Y1_n, Y2_n, Y3_n, Y4_n, Y5_n, Y6_n, Y7_n
  );

  modport slave (
    input  A0, A1, A2, E1, E2_n, E3_n,
    output Y0_n, Y1_n, Y2_n, Y3_n, Y4_n, Y5_n, Y6_n, Y7_n
  );

endinterface

// File: rtl/decode138_core.sv
// decode138_core: purely combinational enable gating and one-cold decode.
// Produces the 8-bit active-low vector the top level registers (or passes
// straight through in the combinational build).
module decode138_core
  import decode138_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  input  logic               e1,
  input  logic               e2_n,
  input  logic               e3_n,
  output logic [NUM_OUT-1:0] y_next
);

  logic en;

  // All three enables must be asserted; any one inactive blanks the outputs.
  always_comb begin
    en     = e1 & ~e2_n & ~e3_n;
    y_next = decode_one_cold(addr, en);
  end

endmodule

// File: rtl/decode_138.sv
// decode_138: 74LS138-style 3-to-8 decoder with active-low outputs.
// Default build registers the decoded vector on clk with a synchronous
// active-high reset to OUT_RST. Defining DECODE138_COMB_EN removes the
// register for zero-latency decoding; clk, rst and OUT_RST are then unused.
module decode_138
  import decode138_pkg::*;
#(
  parameter logic [NUM_OUT-1:0] OUT_RST = Y_INACTIVE
) (
  input logic           clk,
  input logic           rst,
  decode138_if.slave    bus
);

  logic [NUM_OUT-1:0] y_d;
  logic [NUM_OUT-1:0] y_out;

  decode138_core u_core (
    .addr   ({bus.A2, bus.A1, bus.A0}),
    .e1     (bus.E1),
    .e2_n   (bus.E2_n),
    .e3_n   (bus.E3_n),
    .y_next (y_d)
  );

`ifdef DECODE138_COMB_EN
  // Classic 74LS138 timing: outputs follow the inputs with no register.
  always_comb begin
    y_out = y_d;
  end
`else
  logic [NUM_OUT-1:0] y_q;

  // The only state in the design: one register stage on the decoded vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= OUT_RST;
    end else begin
      y_q <= y_d;
    end
  end

  // Registered vector drives the pins.
  always_comb begin
    y_out = y_q;
  end
`endif

  assign bus.Y0_n = y_out[0];
  assign bus.Y1_n = y_out[1];
  assign bus.Y2_n = y_out[2];
  assign bus.Y3_n = y_out[3];
  assign bus.Y4_n = y_out[4];
  assign bus.Y5_n = y_out[5];
  assign bus.Y6_n = y_out[6];
  assign bus.Y7_n = y_out[7];

endmodule

// File: tb/tb_decode_138.sv
// tb_decode_138: scoreboard bench for decode_138. Stimulus rows are driven on
// the falling edge and their hand-computed expected outputs queued; a monitor
// pops one entry just after each rising edge and compares it with the pins.
// Rows carry a separate expectation for the DECODE138_COMB_EN build, where
// reset has no effect on the outputs.
module tb_decode_138;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   vec_idx;
  logic [7:0] exp_q[$];

  decode138_if bus ();

  decode_138 #(.OUT_RST(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one row on the falling edge and queues the output expected after
  // the following rising edge.
  task automatic applyStimulus(
    input logic       r,
    input logic [2:0] a,
    input logic       e1,
    input logic       e2n,
    input logic       e3n,
    input logic [7:0] exp_reg,
    input logic [7:0] exp_comb
  );
    @(negedge clk);
    rst      = r;
    bus.A0   = a[0];
    bus.A1   = a[1];
    bus.A2   = a[2];
    bus.E1   = e1;
    bus.E2_n = e2n;
    bus.E3_n = e3n;
`ifdef DECODE138_COMB_EN
    exp_q.push_back(exp_comb);
`else
    exp_q.push_back(exp_reg);
`endif
  endtask

  // Compares the output pins against one expected vector.
  task automatic checkOutput(input logic [7:0] exp_y);
    logic [7:0] got;
    got = {bus.Y7_n, bus.Y6_n, bus.Y5_n, bus.Y4_n,
           bus.Y3_n, bus.Y2_n, bus.Y1_n, bus.Y0_n};
    checks++;
    if (got !== exp_y) begin
      errors++;
      $display("[TB] FAIL vec%0d: Y got=%h expected=%h", vec_idx, got, exp_y);
    end
    vec_idx++;
  endtask

  // Monitor: samples 1 ns after each rising edge and checks queued entries.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed stimulus table.
  initial begin
    errors   = 0;
    checks   = 0;
    vec_idx  = 0;
    rst      = 1'b1;
    bus.A0   = 1'b0;
    bus.A1   = 1'b0;
    bus.A2   = 1'b0;
    bus.E1   = 1'b0;
    bus.E2_n = 1'b1;
    bus.E3_n = 1'b1;

    // Reset held two cycles with A=5 enabled, then release.
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hDF);
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hDF);
    applyStimulus(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'hDF, 8'hDF);

    // E1 low: address sweep must leave every output high.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'(i), 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    end
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE);

    // Full enabled sweep.
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE);
    applyStimulus(1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'hFD, 8'hFD);
    applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'hFB, 8'hFB);
    applyStimulus(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hF7, 8'hF7);
    applyStimulus(1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 8'hEF, 8'hEF);
    applyStimulus(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'hDF, 8'hDF);
    applyStimulus(1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 8'hBF, 8'hBF);
    applyStimulus(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F);

    // E2_n pulse at A=3.
    applyStimulus(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hF7, 8'hF7);
    applyStimulus(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hF7, 8'hF7);

    // E3_n pulse at A=7.
    applyStimulus(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F);
    applyStimulus(1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F);

    // Reset mid-operation at A=6.
    applyStimulus(1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 8'hBF, 8'hBF);
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hBF);
    applyStimulus(1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 8'hBF, 8'hBF);

    // Simultaneous address and enable changes.
    applyStimulus(1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'hFB, 8'hFB);
    applyStimulus(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 8'hEF, 8'hEF);

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
